multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning memory access cycles per fetch, load or store, legal range 1..8.
REQ-002 Parameter SRCB_W, default 3, meaning ALUSrcB width, minimum 3.
REQ-003 clk  input  1  clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 op  input  6  opcode of the instruction register.
REQ-006 cont  input  1  1 selects continuous run; 0 selects single-step.
REQ-007 run  input  1  step request; a 0->1 transition, sampled on clk, requests one instruction.
REQ-008 PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes.
REQ-009 PCSource  output  2, ALUOp  output  2, ALUSrcB  output  SRCB_W  datapath selects.
REQ-010 illegal  output  1  sticky flag; set when an unsupported opcode is decoded.
REQ-011 busy  output  1  1 in every state except IDLE and HALT.
REQ-012 instret  output  32  count of retired instructions.

Function
REQ-013 States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_LOGIC, I_WB, HALT.
REQ-014 Outputs: Moore-decoded from the state and the wait counter; every output is assigned in every state (no latches); any unlisted output is 0.
REQ-015 IDLE exits to FETCH when cont=1 or a run rising edge is detected; otherwise it stays in IDLE.
REQ-016 FETCH:
- lasts exactly MEM_LAT cycles, counted by an internal wait counter;
- MemRead=1, IorD=0, ALUSrcB=1 in every cycle;
- PCWrite=1 and IRWrite=1 only in the last cycle;
- then goes to DECODE.
REQ-017 DECODE: ALUSrcB=3.
- lw/sw (100011/101011) -> MEM_ADDR
- R-type (000000) -> R_EXEC
- beq/bne (000100/000101) -> BRANCH
- j (000010) -> JUMP
- addi/slti (001000/001010) -> I_EXEC
- andi/ori/xori (001100/001101/001110) -> I_LOGIC
- any other opcode -> HALT, with illegal set.
REQ-018 MEM_ADDR: ALUSrcA=1, ALUSrcB=2; goes to MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD: lasts MEM_LAT cycles with MemRead=1, IorD=1; then goes to MEM_WB (MemtoReg=1, RegWrite=1, RegDst=0).
REQ-020 MEM_WR: lasts MEM_LAT cycles with MemWrite=1, IorD=1.
REQ-021 R_EXEC (ALUSrcA=1, ALUOp=2) goes to R_WB (RegWrite=1, RegDst=1).
REQ-022 I_EXEC (ALUSrcB=2) and I_LOGIC (ALUSrcB=4) both drive ALUSrcA=1, ALUOp=3, then go to I_WB (RegWrite=1).
REQ-023 BRANCH drives PCWriteCond=1, PCSource=1, ALUOp=1, ALUSrcA=1; JUMP drives PCWrite=1, PCSource=2.
REQ-024 Completion states are MEM_WB, MEM_WR (last cycle), R_WB, I_WB, BRANCH and JUMP.
- Each goes to FETCH if cont=1, else to IDLE.
- A run edge arriving mid-instruction is held pending and consumed in IDLE.
REQ-025 HALT holds until reset; all strobes are 0.
REQ-026 The wait counter clears on every state entry; MEM_LAT=1 means single-cycle memory states.
REQ-027 Latency from FETCH entry to retirement: R-type and I-type MEM_LAT+3 cycles; lw 2*MEM_LAT+3 cycles.

Reset
REQ-028 On rst_n low:
- state=IDLE, wait counter=0, run edge register=0, pending step=0;
- illegal=0, instret=0;
- all strobes 0.
REQ-029 Reset asserted mid-instruction aborts the instruction with no further strobe; the first post-reset cycle is IDLE.

Configuration
REQ-030 With macro MULTICYCLE_CTRL_INSTRET_EN defined, instret increments by 1 in each completion cycle, wrapping from 0xFFFFFFFF to 0.
REQ-031 Without MULTICYCLE_CTRL_INSTRET_EN, instret is constant 0 and no counter flops are built.

Structure
REQ-032 Shared package multicycle_ctrl_pkg holds:
- the state enumeration;
- the opcode constants;
- the ALUOp, PCSource and ALUSrcB encodings.
REQ-033 The wait counter is sub-module mc_wait_cnt, width $clog2(MEM_LAT+1), with start and done ports.

Verification
REQ-034 MEM_LAT=2, cont=1, op=000000 -> FETCH for 2 cycles, IRWrite only in the 2nd; RegWrite=1 with RegDst=1 in cycle 5; FETCH re-entered in cycle 6.
REQ-035 MEM_LAT=2, op=100011 -> MemRead with IorD=1 for exactly 2 cycles, then MemtoReg=1 and RegWrite=1; retirement 7 cycles after FETCH entry.
REQ-036 cont=0, one run pulse -> exactly one instruction executes, then IDLE persists with busy=0 until the next run rising edge.
REQ-037 op=111111 at DECODE -> HALT, illegal=1 sticky, all strobes 0; rst_n low clears illegal to 0.
REQ-038 rst_n pulsed low during MEM_WR -> MemWrite drops asynchronously, state=IDLE.
REQ-039 With MULTICYCLE_CTRL_INSTRET_EN, instret forced to 0xFFFFFFFF, one completion -> 0; without the macro instret stays 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-style controller: state set,
// opcodes, datapath select encodings and the opcode-to-state decode.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        R_EXEC,
        R_WB,
        BRANCH,
        JUMP,
        I_EXEC,
        I_LOGIC,
        I_WB,
        HALT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_IMM   = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALUSrcB width is a parameter of the controller, so these stay integers
    localparam int SRCB_REG   = 0;
    localparam int SRCB_FOUR  = 1;
    localparam int SRCB_IMM   = 2;
    localparam int SRCB_BROFF = 3;
    localparam int SRCB_ZEXT  = 4;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } strobes_t;

    function automatic state_e decode_state(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:             return MEM_ADDR;
            OP_RTYPE:                 return R_EXEC;
            OP_BEQ, OP_BNE:           return BRANCH;
            OP_J:                     return JUMP;
            OP_ADDI, OP_SLTI:         return I_EXEC;
            OP_ANDI, OP_ORI, OP_XORI: return I_LOGIC;
            default:                  return HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/run controls in, strobes and
// status out. master = controller side, slave = datapath/host side.
interface multicycle_ctrl_if
    import multicycle_ctrl_pkg::*;
#(
    parameter int SRCB_W = 3
) ();

    logic [5:0]        op;
    logic              cont;
    logic              run;

    logic              PCWriteCond;
    logic              PCWrite;
    logic              IorD;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              IRWrite;
    logic              ALUSrcA;
    logic              RegWrite;
    logic              RegDst;
    logic [1:0]        PCSource;
    logic [1:0]        ALUOp;
    logic [SRCB_W-1:0] ALUSrcB;

    logic              illegal;
    logic              busy;
    logic [31:0]       instret;

    modport master (
        input  op, cont, run,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               illegal, busy, instret
    );

    modport slave (
        output op, cont, run,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
               illegal, busy, instret
    );

endinterface

// File: rtl/mc_wait_cnt.sv
// Per-state wait counter: cleared by start, saturates at MEM_LAT-1 where
// done is raised, so MEM_LAT=1 gives done in the first cycle of every state.
module mc_wait_cnt #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int W = $clog2(MEM_LAT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with Moore-decoded datapath strobes.
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int SRCB_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_e state_q, state_d;
    logic   run_q, run_d;
    logic   pend_q, pend_d;
    logic   illegal_q, illegal_d;
    logic   run_edge;
    logic   wait_start, wait_done;
    state_e done_next;

    strobes_t          ctl;
    logic [SRCB_W-1:0] srcb_sel;

    assign run_edge  = bus.run & ~run_q;
    assign done_next = bus.cont ? FETCH : IDLE;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        run_d     = bus.run;
        // a step request seen while busy waits here until IDLE consumes it
        pend_d    = pend_q | run_edge;
        unique case (state_q)
            IDLE: begin
                if (bus.cont || run_edge || pend_q) begin
                    state_d = FETCH;
                    pend_d  = 1'b0;
                end
            end
            FETCH:    if (wait_done) state_d = DECODE;
            DECODE: begin
                state_d = decode_state(bus.op);
                if (state_d == HALT) illegal_d = 1'b1;
            end
            MEM_ADDR: state_d = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (wait_done) state_d = MEM_WB;
            MEM_WR:   if (wait_done) state_d = done_next;
            R_EXEC:   state_d = R_WB;
            I_EXEC,
            I_LOGIC:  state_d = I_WB;
            MEM_WB,
            R_WB,
            I_WB,
            BRANCH,
            JUMP:     state_d = done_next;
            HALT:     state_d = HALT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            pend_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pend_q    <= pend_d;
            illegal_q <= illegal_d;
        end
    end

    // every state change restarts the memory wait
    assign wait_start = (state_d != state_q);

    mc_wait_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (wait_start),
        .done  (wait_done)
    );

    always_comb begin
        ctl           = '0;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        srcb_sel      = SRCB_W'(SRCB_REG);
        unique case (state_q)
            FETCH: begin
                ctl.mem_read = 1'b1;
                srcb_sel     = SRCB_W'(SRCB_FOUR);
                if (wait_done) begin
                    ctl.pc_write = 1'b1;
                    ctl.ir_write = 1'b1;
                end
            end
            DECODE:   srcb_sel = SRCB_W'(SRCB_BROFF);
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                srcb_sel      = SRCB_W'(SRCB_IMM);
            end
            MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_IMM;
                srcb_sel      = SRCB_W'(SRCB_IMM);
            end
            I_LOGIC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_IMM;
                srcb_sel      = SRCB_W'(SRCB_ZEXT);
            end
            I_WB:     ctl.reg_write = 1'b1;
            BRANCH: begin
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.alu_op        = ALUOP_SUB;
                ctl.alu_src_a     = 1'b1;
            end
            JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.PCWrite     = ctl.pc_write;
    assign bus.IorD        = ctl.i_or_d;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.ALUOp       = ctl.alu_op;
    assign bus.ALUSrcB     = srcb_sel;
    assign bus.illegal     = illegal_q;
    assign bus.busy        = (state_q != IDLE) && (state_q != HALT);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic        retire;
    logic [31:0] instret_q, instret_d;

    // a store retires on its last write cycle, everything else on its final state
    assign retire = (state_q == MEM_WB) || (state_q == R_WB) || (state_q == I_WB) ||
                    (state_q == BRANCH) || (state_q == JUMP) ||
                    ((state_q == MEM_WR) && wait_done);

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign bus.instret = instret_q;
`else
    assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (MEM_LAT=2): per-instruction strobe schedules
// checked every cycle, plus directed literal checks.
module tb_multicycle_ctrl;

    localparam int L = 2;

    localparam logic [16:0] S_PCWC = 17'h10000;
    localparam logic [16:0] S_PCW  = 17'h08000;
    localparam logic [16:0] S_IORD = 17'h04000;
    localparam logic [16:0] S_MR   = 17'h02000;
    localparam logic [16:0] S_MW   = 17'h01000;
    localparam logic [16:0] S_M2R  = 17'h00800;
    localparam logic [16:0] S_IRW  = 17'h00400;
    localparam logic [16:0] S_ASA  = 17'h00200;
    localparam logic [16:0] S_RW   = 17'h00100;
    localparam logic [16:0] S_RD   = 17'h00080;

    typedef struct {
        logic [16:0] v;
        bit          last;
        bit          hlt;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cyc_t        mq[$];
    bit          m_pend = 0;
    bit          m_prev_run = 0;
    bit          m_halted = 0;
    bit          m_illegal = 0;
    logic [31:0] m_instret = '0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.SRCB_W(3)) bus ();

    multicycle_ctrl #(
        .MEM_LAT (L),
        .SRCB_W  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [16:0] sb(input int v);  return 17'(v);      endfunction
    function automatic logic [16:0] aop(input int v); return 17'(v) << 3; endfunction
    function automatic logic [16:0] pcs(input int v); return 17'(v) << 5; endfunction

    function automatic logic [16:0] dv();
        return {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUOp, bus.ALUSrcB};
    endfunction

    function automatic logic [31:0] e_instret();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        return m_instret;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input logic [16:0] v, input bit last, input bit hlt);
        cyc_t c;
        c.v = v; c.last = last; c.hlt = hlt;
        mq.push_back(c);
    endtask

    // whole-instruction strobe schedule, one entry per cycle from FETCH entry
    task automatic push_instr(input logic [5:0] o);
        for (int i = 0; i < L; i++)
            push(S_MR | sb(1) | ((i == L - 1) ? (S_PCW | S_IRW) : 17'h0), 0, 0);
        case (o)
            6'b100011: begin
                push(sb(3), 0, 0); push(S_ASA | sb(2), 0, 0);
                for (int i = 0; i < L; i++) push(S_MR | S_IORD, 0, 0);
                push(S_M2R | S_RW, 1, 0);
            end
            6'b101011: begin
                push(sb(3), 0, 0); push(S_ASA | sb(2), 0, 0);
                for (int i = 0; i < L; i++) push(S_MW | S_IORD, i == L - 1, 0);
            end
            6'b000000: begin
                push(sb(3), 0, 0); push(S_ASA | aop(2), 0, 0); push(S_RW | S_RD, 1, 0);
            end
            6'b000100, 6'b000101: begin
                push(sb(3), 0, 0); push(S_PCWC | pcs(1) | aop(1) | S_ASA, 1, 0);
            end
            6'b000010: begin
                push(sb(3), 0, 0); push(S_PCW | pcs(2), 1, 0);
            end
            6'b001000, 6'b001010: begin
                push(sb(3), 0, 0); push(S_ASA | aop(3) | sb(2), 0, 0); push(S_RW, 1, 0);
            end
            6'b001100, 6'b001101, 6'b001110: begin
                push(sb(3), 0, 0); push(S_ASA | aop(3) | sb(4), 0, 0); push(S_RW, 1, 0);
            end
            default: push(sb(3), 0, 1);
        endcase
    endtask

    task automatic model_step();
        cyc_t c;
        bit   edg;
        edg = bus.run && !m_prev_run;
        m_prev_run = bus.run;
        if (m_halted) begin
        end else if (mq.size() == 0) begin
            if (bus.cont || edg || m_pend) begin
                m_pend = 0;
                push_instr(bus.op);
            end
        end else begin
            c = mq.pop_front();
            if (edg) m_pend = 1;
            if (c.hlt) begin
                m_halted = 1; m_illegal = 1; mq.delete();
            end else if (c.last) begin
                m_instret = m_instret + 32'd1;
                if (bus.cont) push_instr(bus.op);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pend = 0; m_prev_run = 0; m_halted = 0; m_illegal = 0; m_instret = '0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        logic [16:0] e_v;
        bit          e_busy;
        forever begin
            @(negedge clk);
            e_v    = (mq.size() != 0) ? mq[0].v : 17'h0;
            e_busy = (mq.size() != 0);
            checks++;
            if (dv() !== e_v || bus.busy !== e_busy || bus.illegal !== m_illegal ||
                bus.instret !== e_instret()) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t strobes act=%h exp=%h busy act=%b exp=%b illegal act=%b exp=%b instret act=%h exp=%h",
                         $time, dv(), e_v, bus.busy, e_busy, bus.illegal, m_illegal,
                         bus.instret, e_instret());
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n = 0;
        while (bus.busy === 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic step(input logic [5:0] o);
        bus.op = o; bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [8];
        int n;
        ops = '{6'b000100, 6'b000101, 6'b000010, 6'b001000,
                6'b001010, 6'b001100, 6'b001101, 6'b001110};
        bus.op = 6'b000000; bus.cont = 1'b0; bus.run = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_illegal", {31'd0, bus.illegal}, 0);
        chk("rst_instret", bus.instret, 0);
        chk("rst_strobes", {15'd0, dv()}, 0);
        #2 rst_n = 1'b1;
        tick(); tick();

        // continuous R-type: 2-cycle fetch, write-back in cycle 5, refetch in 6
        bus.cont = 1'b1; bus.op = 6'b000000;
        tick();
        chk("r_c1_fetch", {30'd0, bus.MemRead, bus.IRWrite}, 32'b10);
        tick();
        chk("r_c2_irw", {30'd0, bus.IRWrite, bus.PCWrite}, 32'b11);
        repeat (3) tick();
        chk("r_c5_wb", {30'd0, bus.RegWrite, bus.RegDst}, 32'b11);
        tick();
        chk("r_c6_refetch", {30'd0, bus.MemRead, bus.IRWrite}, 32'b10);
        bus.cont = 1'b0;
        wait_idle(20, "r_stop");
        repeat (4) tick();
        chk("idle_hold", {31'd0, bus.busy}, 0);

        // single-step lw
        step(6'b100011);
        chk("lw_c1_busy", {31'd0, bus.busy}, 1);
        repeat (4) tick();
        chk("lw_c5_rd", {30'd0, bus.MemRead, bus.IorD}, 32'b11);
        tick();
        chk("lw_c6_rd", {30'd0, bus.MemRead, bus.IorD}, 32'b11);
        tick();
        chk("lw_c7_wb", {29'd0, bus.MemRead, bus.MemtoReg, bus.RegWrite}, 32'b011);
        tick();
        chk("lw_c8_idle", {31'd0, bus.busy}, 0);
        repeat (5) tick();
        chk("step_idle", {31'd0, bus.busy}, 0);

        // run edge during sw decode is held and replayed after one IDLE cycle
        step(6'b101011);
        tick(); tick();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick(); tick(); tick();
        chk("pend_gap", {31'd0, bus.busy}, 0);
        tick();
        chk("pend_restart", {31'd0, bus.busy}, 1);
        wait_idle(30, "pend_done");

        foreach (ops[i]) begin
            step(ops[i]);
            wait_idle(20, "op_done");
        end

        bus.op = 6'b000010; bus.cont = 1'b1;
        repeat (13) tick();
        bus.cont = 1'b0;
        wait_idle(20, "j_burst_done");

        // reset in the first MEM_WR cycle kills MemWrite immediately
        step(6'b101011);
        n = 0;
        while (bus.MemWrite !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("mw_seen", {31'd0, bus.MemWrite}, 1);
        #1 rst_n = 1'b0;
        #1 chk("mw_async_drop", {31'd0, bus.MemWrite}, 0);
        chk("mw_rst_busy", {31'd0, bus.busy}, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, bus.busy}, 0);

        // unsupported opcode
        step(6'b111111);
        tick(); tick();
        chk("dec_no_illegal", {31'd0, bus.illegal}, 0);
        tick();
        chk("halt_illegal", {31'd0, bus.illegal}, 1);
        chk("halt_strobes", {15'd0, dv()}, 0);
        chk("halt_busy", {31'd0, bus.busy}, 0);
        step(6'b000000);
        repeat (3) tick();
        chk("halt_sticky", {30'd0, bus.illegal, bus.busy}, 32'b10);
        bus.cont = 1'b1;
        repeat (3) tick();
        chk("halt_cont", {30'd0, bus.illegal, bus.busy}, 32'b10);
        bus.cont = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        chk("rst_clr_illegal", {31'd0, bus.illegal}, 0);
        #2 rst_n = 1'b1;
        tick();

`ifdef MULTICYCLE_CTRL_INSTRET_EN
        #1;
        dut.instret_q = 32'hFFFF_FFFF;
        m_instret = 32'hFFFF_FFFF;
        step(6'b000010);
        wait_idle(20, "wrap_done");
        chk("instret_wrap", bus.instret, 0);
`else
        step(6'b000010);
        wait_idle(20, "j_done");
        chk("instret_off", bus.instret, 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
